// File: rtl/ahb_hart_mem_arbiter.sv
// Shares one AHB-lite slave port among N_HARTS hart masters, each with a one-entry address buffer.
// Define ARB_FIXED_PRIO_EN for lowest-index-wins arbitration instead of round-robin.
module ahb_hart_mem_arbiter #(
  parameter int unsigned N_HARTS = 2,
  parameter int unsigned W_ADDR  = 32,
  parameter int unsigned W_DATA  = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [2*N_HARTS-1:0]        m_htrans,
  input  logic [W_ADDR*N_HARTS-1:0]   m_haddr,
  input  logic [N_HARTS-1:0]          m_hwrite,
  input  logic [3*N_HARTS-1:0]        m_hsize,
  input  logic [N_HARTS-1:0]          m_hexcl,
  input  logic [W_DATA*N_HARTS-1:0]   m_hwdata,
  output logic [N_HARTS-1:0]          m_hready,
  output logic [W_DATA-1:0]           m_hrdata,
  output logic [N_HARTS-1:0]          m_hexokay,
  output logic [N_HARTS-1:0]          m_hresp,
  output logic [1:0]                  s_htrans,
  output logic [W_ADDR-1:0]           s_haddr,
  output logic                        s_hwrite,
  output logic [2:0]                  s_hsize,
  output logic                        s_hexcl,
  output logic [7:0]                  s_hmaster,
  output logic [W_DATA-1:0]           s_hwdata,
  output logic                        s_hready,
  output logic [W_DATA-1:0]           s_hartid,
  input  logic                        s_hready_resp,
  input  logic [W_DATA-1:0]           s_hrdata,
  input  logic                        s_hexokay,
  input  logic                        s_hresp
);

  localparam int unsigned W_IDX = (N_HARTS > 1) ? $clog2(N_HARTS) : 1;

  typedef struct packed {
    logic [W_ADDR-1:0] addr;
    logic              write;
    logic [2:0]        size;
    logic              excl;
  } req_t;

  typedef enum logic {ST_IDLE, ST_DATA} state_t;

  state_t             state_q, state_d;
  logic [N_HARTS-1:0] pend_q, pend_d;
  logic [W_IDX-1:0]   grant_q, grant_d;
  req_t               req_q [N_HARTS];
`ifndef ARB_FIXED_PRIO_EN
  logic [W_IDX-1:0]   rr_q, rr_d;
`endif

  req_t               in_req [N_HARTS];
  logic [W_DATA-1:0]  wdata_a [N_HARTS];
  logic [N_HARTS-1:0] cap_c;
  logic [W_IDX-1:0]   pick_c, sel_c, idx_c;
  logic               issue_c, done_c;

  // Unpack the flat per-master buses.
  always_comb begin : unpack
    for (int i = 0; i < int'(N_HARTS); i++) begin
      in_req[i].addr  = m_haddr[i*W_ADDR +: W_ADDR];
      in_req[i].write = m_hwrite[i];
      in_req[i].size  = m_hsize[3*i +: 3];
      in_req[i].excl  = m_hexcl[i];
      wdata_a[i]      = m_hwdata[i*W_DATA +: W_DATA];
    end
  end

  // Arbitration: later loop iterations override, so the closest eligible index wins.
  always_comb begin : pick
    pick_c = grant_q;
    idx_c  = '0;
`ifdef ARB_FIXED_PRIO_EN
    for (int k = int'(N_HARTS) - 1; k >= 0; k--) begin
      idx_c = W_IDX'(k);
      if (pend_q[idx_c]) pick_c = idx_c;
    end
`else
    for (int unsigned k = N_HARTS; k >= 1; k--) begin
      idx_c = W_IDX'((32'(rr_q) + k) % N_HARTS);
      if (pend_q[idx_c]) pick_c = idx_c;
    end
`endif
  end

  // Transfer sequencing: one address phase, then a data phase held until the slave is ready.
  always_comb begin : ctrl
    state_d = state_q;
    grant_d = grant_q;
    issue_c = 1'b0;
    done_c  = 1'b0;
`ifndef ARB_FIXED_PRIO_EN
    rr_d    = rr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if ((|pend_q) && s_hready_resp) begin
          issue_c = 1'b1;
          state_d = ST_DATA;
          grant_d = pick_c;
`ifndef ARB_FIXED_PRIO_EN
          rr_d    = pick_c;
`endif
        end
      end
      ST_DATA: begin
        if (s_hready_resp) begin
          done_c  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Master-facing responses; only the granted master sees slave status.
  always_comb begin : mresp
    m_hready  = ~pend_q;
    m_hexokay = '1;
    m_hresp   = '0;
    if (state_q == ST_DATA) begin
      m_hresp[grant_q] = s_hresp;
      if (done_c) begin
        m_hready[grant_q]  = 1'b1;
        m_hexokay[grant_q] = s_hexokay;
      end
    end
  end

  // Capture may coincide with completion, so the buffer is refilled as the old entry retires.
  always_comb begin : capture
    for (int i = 0; i < int'(N_HARTS); i++) begin
      cap_c[i] = m_hready[i] && ((m_htrans[2*i +: 2] == 2'b10) || (m_htrans[2*i +: 2] == 2'b11));
    end
    pend_d = pend_q;
    if (done_c) pend_d[grant_q] = 1'b0;
    pend_d = pend_d | cap_c;
  end

  assign sel_c     = issue_c ? pick_c : grant_q;
  assign s_htrans  = issue_c ? 2'b10 : 2'b00;
  assign s_haddr   = req_q[sel_c].addr;
  assign s_hwrite  = req_q[sel_c].write;
  assign s_hsize   = req_q[sel_c].size;
  assign s_hexcl   = req_q[sel_c].excl;
  assign s_hmaster = 8'(sel_c);
  assign s_hartid  = W_DATA'(sel_c);
  assign s_hwdata  = wdata_a[grant_q];
  assign s_hready  = s_hready_resp;
  assign m_hrdata  = s_hrdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      grant_q <= '0;
`ifndef ARB_FIXED_PRIO_EN
      rr_q    <= W_IDX'(N_HARTS - 1);
`endif
      for (int i = 0; i < int'(N_HARTS); i++) req_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      grant_q <= grant_d;
`ifndef ARB_FIXED_PRIO_EN
      rr_q    <= rr_d;
`endif
      for (int i = 0; i < int'(N_HARTS); i++) begin
        if (cap_c[i]) req_q[i] <= in_req[i];
      end
    end
  end

endmodule

// File: tb/tb_ahb_hart_mem_arbiter.sv
// Randomized and directed bench for ahb_hart_mem_arbiter against a transaction-level model.
module tb_ahb_hart_mem_arbiter;
  localparam int NH = 2;

  logic clk, rst_n;
  logic [2*NH-1:0]  m_htrans;
  logic [32*NH-1:0] m_haddr;
  logic [NH-1:0]    m_hwrite;
  logic [3*NH-1:0]  m_hsize;
  logic [NH-1:0]    m_hexcl;
  logic [32*NH-1:0] m_hwdata;
  logic [NH-1:0]    m_hready, m_hexokay, m_hresp;
  logic [31:0]      m_hrdata;
  logic [1:0]       s_htrans;
  logic [31:0]      s_haddr, s_hwdata, s_hartid, s_hrdata;
  logic             s_hwrite, s_hexcl, s_hready, s_hready_resp, s_hexokay, s_hresp;
  logic [2:0]       s_hsize;
  logic [7:0]       s_hmaster;

  logic [1:0]  tr [NH];
  logic [31:0] ad [NH];
  logic        wr [NH];
  logic [2:0]  sz [NH];
  logic        exq[NH];
  logic [31:0] wd [NH];

  int n_tests = 0;
  int n_fail  = 0;

  ahb_hart_mem_arbiter #(.N_HARTS(NH), .W_ADDR(32), .W_DATA(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_htrans(m_htrans), .m_haddr(m_haddr), .m_hwrite(m_hwrite), .m_hsize(m_hsize),
    .m_hexcl(m_hexcl), .m_hwdata(m_hwdata), .m_hready(m_hready), .m_hrdata(m_hrdata),
    .m_hexokay(m_hexokay), .m_hresp(m_hresp),
    .s_htrans(s_htrans), .s_haddr(s_haddr), .s_hwrite(s_hwrite), .s_hsize(s_hsize),
    .s_hexcl(s_hexcl), .s_hmaster(s_hmaster), .s_hwdata(s_hwdata), .s_hready(s_hready),
    .s_hartid(s_hartid), .s_hready_resp(s_hready_resp), .s_hrdata(s_hrdata),
    .s_hexokay(s_hexokay), .s_hresp(s_hresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NH; i++) begin
      m_htrans[2*i +: 2]  = tr[i];
      m_haddr[32*i +: 32] = ad[i];
      m_hwrite[i]         = wr[i];
      m_hsize[3*i +: 3]   = sz[i];
      m_hexcl[i]          = exq[i];
      m_hwdata[32*i +: 32] = wd[i];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [NH-1:0] mp;
  logic [31:0]   mad [NH];
  logic          mwr [NH];
  logic [2:0]    msz [NH];
  logic          mex [NH];
  bit            mbusy;
  int            mcur, mrr;
  logic [NH-1:0] acc;

  function automatic int pick();
`ifdef ARB_FIXED_PRIO_EN
    for (int k = 0; k < NH; k++) if (mp[k]) return k;
`else
    for (int k = 1; k <= NH; k++) if (mp[(mrr + k) % NH]) return (mrr + k) % NH;
`endif
    return 0;
  endfunction

  always @(negedge clk) begin : mdl
    logic done, issue;
    int g;
    logic [NH-1:0] eh, eok, ersp;
    if (!rst_n) begin
      chk("rst_hready", m_hready, {NH{1'b1}});
      chk("rst_htrans", s_htrans, 2'b00);
      chk("rst_hmaster", s_hmaster, 0);
      chk("rst_hartid", s_hartid, 0);
      chk("rst_hexokay", m_hexokay, {NH{1'b1}});
      chk("rst_hresp", m_hresp, 0);
      mp = '0; mbusy = 0; mcur = 0; mrr = NH - 1; acc = '0;
    end else begin
      done  = mbusy && s_hready_resp;
      issue = !mbusy && (|mp) && s_hready_resp;
      g     = pick();
      eh = ~mp;
      if (done) eh[mcur] = 1'b1;
      eok = '1; ersp = '0;
      if (mbusy) ersp[mcur] = s_hresp;
      if (done) eok[mcur] = s_hexokay;
      chk("m_hready", m_hready, eh);
      chk("m_hexokay", m_hexokay, eok);
      chk("m_hresp", m_hresp, ersp);
      chk("s_hready", s_hready, s_hready_resp);
      chk("s_htrans", s_htrans, issue ? 2'b10 : 2'b00);
      if (issue) begin
        chk("s_haddr", s_haddr, mad[g]);
        chk("s_hwrite", s_hwrite, mwr[g]);
        chk("s_hsize", s_hsize, msz[g]);
        chk("s_hexcl", s_hexcl, mex[g]);
        chk("s_hmaster_addr", s_hmaster, g);
        chk("s_hartid_addr", s_hartid, g);
      end
      if (mbusy) begin
        chk("s_hmaster_data", s_hmaster, mcur);
        chk("s_hartid_data", s_hartid, mcur);
        chk("s_hwdata", s_hwdata, wd[mcur]);
      end
      if (done) chk("m_hrdata", m_hrdata, s_hrdata);
      if (done) begin mp[mcur] = 1'b0; mbusy = 0; end
      if (issue) begin mbusy = 1; mcur = g; mrr = g; end
      for (int i = 0; i < NH; i++) begin
        acc[i] = tr[i][1] && eh[i];
        if (acc[i]) begin
          mp[i] = 1'b1; mad[i] = ad[i]; mwr[i] = wr[i]; msz[i] = sz[i]; mex[i] = exq[i];
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic single(input int m, input logic [31:0] a, input logic w, input logic ex,
                        input logic [31:0] wdat, input logic [31:0] rdat, input logic xok,
                        input int waits);
    tick();
    tr[m] = 2'b10; ad[m] = a; wr[m] = w; exq[m] = ex; sz[m] = 3'd2; s_hready_resp = 1'b1;
    tick();
    tr[m] = 2'b00; wd[m] = wdat;
    smp();
    chk("addr_htrans", s_htrans, 2'b10);
    chk("addr_haddr", s_haddr, a);
    chk("addr_hexcl", s_hexcl, ex);
    chk("addr_hmaster", s_hmaster, m);
    chk("addr_hready", m_hready[m], 1'b0);
    for (int k = 0; k < waits; k++) begin
      tick(); s_hready_resp = 1'b0;
      smp();
      chk("wait_hready", m_hready[m], 1'b0);
      chk("wait_hwdata", s_hwdata, wdat);
    end
    tick(); s_hready_resp = 1'b1; s_hrdata = rdat; s_hexokay = xok; s_hresp = 1'b0;
    smp();
    chk("done_hready", m_hready[m], 1'b1);
    chk("done_hexokay", m_hexokay[m], xok);
    if (w) chk("done_hwdata", s_hwdata, wdat);
    else   chk("done_hrdata", m_hrdata, rdat);
    tick(); s_hexokay = 1'b1; s_hrdata = '0;
  endtask

  bit          nv  [NH];
  logic [1:0]  ntr [NH];
  logic [31:0] nwd [NH];

  initial begin
    int ng;
    int gseq [4];
    rst_n = 1'b0;
    for (int i = 0; i < NH; i++) begin
      tr[i] = 2'b00; ad[i] = '0; wr[i] = 1'b0; sz[i] = 3'd2; exq[i] = 1'b0; wd[i] = '0;
      nv[i] = 0; ntr[i] = 2'b00; nwd[i] = '0;
    end
    s_hready_resp = 1'b1; s_hrdata = '0; s_hexokay = 1'b1; s_hresp = 1'b0;
    repeat (2) tick();
    chk("lit_rst_hready", m_hready, 2'b11);
    chk("lit_rst_htrans", s_htrans, 2'b00);
    rst_n = 1'b1;

    // zero-wait read, then a write with three wait states
    single(0, 32'h8000_0010, 1'b0, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b1, 0);
    single(1, 32'h8000_0100, 1'b1, 1'b0, 32'h1234_5678, 32'h0, 1'b1, 3);

    // exclusive pairs, the second interleaved with master 1 and failing
    single(0, 32'h8000_0200, 1'b0, 1'b1, 32'h0, 32'h1111_0000, 1'b1, 0);
    single(0, 32'h8000_0200, 1'b1, 1'b1, 32'hAAAA_5555, 32'h0, 1'b1, 0);
    single(0, 32'h8000_0200, 1'b0, 1'b1, 32'h0, 32'h2222_0000, 1'b1, 1);
    single(1, 32'h8000_0500, 1'b0, 1'b0, 32'h0, 32'h3333_0000, 1'b1, 0);
    single(0, 32'h8000_0200, 1'b1, 1'b1, 32'h5555_AAAA, 32'h0, 1'b0, 0);

    // simultaneous requests out of reset
    do_reset();
    tick();
    tr[0] = 2'b10; ad[0] = 32'h8000_0300; wr[0] = 1'b0; exq[0] = 1'b0;
    tr[1] = 2'b10; ad[1] = 32'h8000_0400; wr[1] = 1'b0; exq[1] = 1'b0;
    tick();
    tr[0] = 2'b00; tr[1] = 2'b00;
    smp();
    chk("sim_first_master", s_hmaster, 8'd0);
    chk("sim_first_addr", s_haddr, 32'h8000_0300);
    tick(); smp();
    chk("sim_gap_htrans", s_htrans, 2'b00);
    tick(); smp();
    chk("sim_second_htrans", s_htrans, 2'b10);
    chk("sim_second_master", s_hmaster, 8'd1);
    chk("sim_second_addr", s_haddr, 32'h8000_0400);
    tick(); smp();
    chk("sim_done_hready", m_hready, 2'b11);

    // reset during a stalled data phase
    tick();
    tr[0] = 2'b10; ad[0] = 32'h8000_0600; s_hready_resp = 1'b1;
    tick(); tr[0] = 2'b00;
    tick(); s_hready_resp = 1'b0;
    smp();
    chk("stall_hready", m_hready[0], 1'b0);
    tick(); rst_n = 1'b0; #1;
    chk("rst_mid_hready", m_hready, 2'b11);
    chk("rst_mid_htrans", s_htrans, 2'b00);
    tick(); tick(); rst_n = 1'b1; s_hready_resp = 1'b1;
    smp();
    chk("post_rst_htrans", s_htrans, 2'b00);
    tick(); smp();
    chk("post_rst_htrans2", s_htrans, 2'b00);
    chk("post_rst_hready", m_hready, 2'b11);

    // both masters requesting continuously
    do_reset();
    tick();
    tr[0] = 2'b10; ad[0] = 32'h8000_0700; tr[1] = 2'b10; ad[1] = 32'h8000_0800;
    ng = 0;
    for (int c = 0; c < 16; c++) begin
      smp();
      if (s_htrans == 2'b10 && ng < 4) begin gseq[ng] = int'(s_hmaster); ng++; end
      tick();
    end
    chk("alt_count", ng, 4);
    for (int k = 0; k < 4; k++) begin
      if (k < ng) begin
`ifdef ARB_FIXED_PRIO_EN
        chk("alt_grant", gseq[k], 0);
`else
        chk("alt_grant", gseq[k], k % 2);
`endif
      end
    end
    tr[0] = 2'b00; tr[1] = 2'b00;
    repeat (8) tick();

    // randomized traffic with random slave wait states and responses
    for (int i = 0; i < NH; i++) nv[i] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      for (int i = 0; i < NH; i++) begin
        if (acc[i]) begin wd[i] = nwd[i]; nv[i] = 0; end
        if (!nv[i] && $urandom_range(0, 2) == 0) begin
          nv[i] = 1;
          ntr[i] = 2'($urandom_range(2, 3));
          ad[i]  = $urandom;
          wr[i]  = 1'($urandom_range(0, 1));
          sz[i]  = 3'($urandom_range(0, 2));
          exq[i] = 1'($urandom_range(0, 1));
          nwd[i] = $urandom;
        end
        tr[i] = nv[i] ? ntr[i] : 2'($urandom_range(0, 1));
      end
      s_hready_resp = ($urandom_range(0, 3) != 0);
      s_hrdata      = $urandom;
      s_hexokay     = 1'($urandom_range(0, 1));
      s_hresp       = ($urandom_range(0, 15) == 0);
    end
    for (int i = 0; i < NH; i++) tr[i] = 2'b00;
    s_hready_resp = 1'b1; s_hresp = 1'b0;
    repeat (12) tick();
    smp();
    chk("drain_hready", m_hready, 2'b11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
